universal_range_counter: RTL and testbench
==========================================

Name: universal_range_counter

Overview:
Parametrised up/down counter with programmable lower and upper bounds, programmable step, and three end-of-range modes: wrap, saturate and one-shot. It replaces fixed 0..2**N-1 counters in timers, tick dividers and address sequencers. It adds a boundary-event pulse and a halt state for one-shot use.

Parameters:
N, 8, counter/bound/load-data width
S, 4, step-size width (step range 0..2**S-1)

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-low reset (asserted when 0)
syn_clr  input  1  synchronous clear: q <= lo, leave HALT
load  input  1  synchronous load of d (clamped), leave HALT
en  input  1  count enable
up  input  1  1 = count up, 0 = count down
mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
step  input  S  increment/decrement amount per enabled cycle
lo  input  N  lower bound (inclusive)
hi  input  N  upper bound (inclusive)
d  input  N  load data
q  output  N  counter value (registered)
max_flag  output  1  q == hi (combinational from register)
min_flag  output  1  q == lo (combinational from register)
tick  output  1  one-cycle registered pulse on boundary event
done  output  1  1 while FSM in HALT
cfg_err  output  1  lo > hi (combinational)

Behaviour:
- Reset (reset==0, async): q=0, tick=0, FSM=RUN, done=0. Deassertion is synchronised externally.
- FSM: RUN, HALT. HALT entered only in one-shot mode when a count reaches or crosses the bound. HALT exits to RUN on syn_clr or load. Mode change alone does not exit HALT.
- Priority per cycle: syn_clr > load > count > hold.
- syn_clr: q <= lo, tick <= 0, FSM <= RUN. Always honoured, even when cfg_err=1.
- load: q <= clamp(d, lo, hi), i.e. lo if d<lo, hi if d>hi, else d. tick <= 0. FSM <= RUN. Ignored when cfg_err=1.
- Count occurs when en=1, FSM=RUN, cfg_err=0 and step!=0. Otherwise q holds and tick <= 0.
- Arithmetic uses N+1-bit intermediates; no silent modular overflow.
- Out-of-range start (q<lo or q>hi, e.g. after reset): a count event sets q <= lo if up, hi if down. tick <= 0.
- Up count, in range: if q+step <= hi, then q <= q+step and tick <= 0. Otherwise it is a boundary event:
  - wrap: q <= lo, residue discarded.
  - saturate: q <= hi.
  - one-shot: q <= hi, FSM <= HALT.
  - In all three cases tick <= 1.
- Down count, in range: if q >= lo+step (N+1-bit compare), then q <= q-step and tick <= 0. Otherwise it is a boundary event:
  - wrap: q <= hi.
  - saturate: q <= lo.
  - one-shot: q <= lo, FSM <= HALT.
  - In all three cases tick <= 1.
- Saturate mode at the bound: each further enabled count re-asserts tick, because it is a boundary event.
- tick is registered and coincides with the cycle q shows the post-event value. It lasts one cycle unless events repeat.
- Latency: 1 cycle from sampled input to q/tick/done update.
- lo==hi is legal. Every enabled count is a boundary event, and q stays at lo.
- Bound changes take effect the next cycle. They are not retroactively applied to q.

Test Plan:
- Reset low mid-count (q=0x37) -> q=0, tick=0, done=0 immediately; after release, syn_clr with lo=0x10 -> q=0x10.
- Wrap up: N=8, lo=0x10, hi=0x14, step=2, up=1, en=1 from q=0x10 -> q sequence 0x12, 0x14, 0x10 (tick=1 on that cycle), 0x12.
- Saturate down: lo=0x05, hi=0x20, step=3, from q=0x0A -> 0x07, 0x05 (tick=1), 0x05 (tick=1), min_flag=1.
- One-shot up: lo=0, hi=0x0F, step=5, from 0 -> 5, 0x0A, 0x0F (tick=1, done=1); en held 1 -> q stays 0x0F, tick=0; load d=0x40 -> q=0x0F (clamped), done=0.
- Priority and config errors: syn_clr, load and en all 1 -> q=lo. lo=0x30, hi=0x20 -> cfg_err=1; load/en ignored; syn_clr -> q=0x30.
- step=0 with en=1 -> q holds, tick=0. Out-of-range q=0 with lo=0x08, down count -> q=hi, tick=0.

Source files
------------

// File: rtl/universal_range_counter.sv
// universal_range_counter: up/down counter between programmable bounds lo..hi
// with a programmable step and wrap / saturate / one-shot end-of-range modes.
// tick pulses (registered) on every boundary event; done flags the one-shot
// HALT state.
module universal_range_counter #(
  parameter int N = 8,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [1:0]   mode,
  input  logic [S-1:0] step,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         max_flag,
  output logic         min_flag,
  output logic         tick,
  output logic         done,
  output logic         cfg_err
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [N-1:0] q_q, q_d;
  logic         tick_q, tick_d;
  logic [0:0]   state_q, state_d;

  // N+1-bit operands so sums/differences never wrap silently
  logic [N:0] q_ext, lo_ext, hi_ext, step_ext, up_sum, lo_step;
  logic       is_sat, is_one, in_range, up_bnd, dn_bnd;

  assign q_ext    = {1'b0, q_q};
  assign lo_ext   = {1'b0, lo};
  assign hi_ext   = {1'b0, hi};
  assign step_ext = (N+1)'(step);
  assign up_sum   = q_ext + step_ext;
  assign lo_step  = lo_ext + step_ext;

  // mode 2'b11 falls through to wrap behaviour
  assign is_sat   = (mode == 2'b01);
  assign is_one   = (mode == 2'b10);
  assign in_range = (q_q >= lo) && (q_q <= hi);

  // One-shot halts when the count reaches the bound as well as when it crosses it
  assign up_bnd = is_one ? (up_sum >= hi_ext) : (up_sum > hi_ext);
  assign dn_bnd = is_one ? (q_ext <= lo_step) : (q_ext < lo_step);

  assign cfg_err  = (lo > hi);
  assign max_flag = (q_q == hi);
  assign min_flag = (q_q == lo);
  assign q        = q_q;
  assign tick     = tick_q;
  assign done     = (state_q == HALT);

  // Next-state: syn_clr > load > count > hold
  always_comb begin
    q_d     = q_q;
    tick_d  = 1'b0;
    state_d = state_q;
    if (syn_clr) begin
      q_d     = lo;
      state_d = RUN;
    end else if (load && !cfg_err) begin
      if (d < lo)      q_d = lo;
      else if (d > hi) q_d = hi;
      else             q_d = d;
      state_d = RUN;
    end else if (en && (state_q == RUN) && !cfg_err && (step != '0)) begin
      if (!in_range) begin
        // Out-of-range start snaps to the bound we are heading away from
        q_d = up ? lo : hi;
      end else if (up) begin
        if (up_bnd) begin
          tick_d = 1'b1;
          q_d    = (is_sat || is_one) ? hi : lo;
          if (is_one) state_d = HALT;
        end else begin
          q_d = up_sum[N-1:0];
        end
      end else begin
        if (dn_bnd) begin
          tick_d = 1'b1;
          q_d    = (is_sat || is_one) ? lo : hi;
          if (is_one) state_d = HALT;
        end else begin
          q_d = q_q - N'(step);
        end
      end
    end
  end

  // State registers, async active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q     <= '0;
      tick_q  <= 1'b0;
      state_q <= RUN;
    end else begin
      q_q     <= q_d;
      tick_q  <= tick_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_universal_range_counter.sv
// Bench for universal_range_counter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_universal_range_counter;
  localparam int N = 8;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         syn_clr, load, en, up;
  logic [1:0]   mode;
  logic [S-1:0] step;
  logic [N-1:0] lo, hi, d;
  logic [N-1:0] q;
  logic         max_flag, min_flag, tick, done, cfg_err;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_q    = 0;
  bit m_tick = 0;
  bit m_halt = 0;

  always #5 clk = ~clk;

  universal_range_counter #(.N(N), .S(S)) dut (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en),
    .up(up), .mode(mode), .step(step), .lo(lo), .hi(hi), .d(d),
    .q(q), .max_flag(max_flag), .min_flag(min_flag), .tick(tick),
    .done(done), .cfg_err(cfg_err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_tick = 0; m_halt = 0;
  endtask

  // One clock of the specification's rules, in plain integer arithmetic
  task automatic model_step();
    int l, h, v, s, nv, dv;
    bit bnd, sat_like;
    l = int'(lo); h = int'(hi); v = m_q; s = int'(step); dv = int'(d);
    m_tick = 0;
    if (syn_clr) begin
      v = l; m_halt = 0;
    end else if (load && l <= h) begin
      v = (dv < l) ? l : (dv > h) ? h : dv;
      m_halt = 0;
    end else if (en && !m_halt && l <= h && s != 0) begin
      if (v < l || v > h) begin
        v = up ? l : h;
      end else begin
        nv  = up ? v + s : v - s;
        bnd = up ? (nv > h || (mode == 2 && nv == h))
                 : (nv < l || (mode == 2 && nv == l));
        if (!bnd) v = nv;
        else begin
          m_tick   = 1;
          sat_like = (mode == 1) || (mode == 2);
          v = sat_like ? (up ? h : l) : (up ? l : h);
          if (mode == 2) m_halt = 1;
        end
      end
    end
    m_q = v;
  endtask

  // Advance one clock and compare every output against the model
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("q",        int'(q),        m_q);
    chk("tick",     int'(tick),     int'(m_tick));
    chk("done",     int'(done),     int'(m_halt));
    chk("max_flag", int'(max_flag), int'(m_q == int'(hi)));
    chk("min_flag", int'(min_flag), int'(m_q == int'(lo)));
    chk("cfg_err",  int'(cfg_err),  int'(lo > hi));
  endtask

  task automatic idle();
    syn_clr = 0; load = 0; en = 0;
  endtask

  initial begin
    reset = 0; syn_clr = 0; load = 0; en = 0; up = 1; mode = 0;
    step = 1; lo = 0; hi = 8'hFF; d = 0;
    model_reset();
    #3;
    chk("reset_q", int'(q), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk); @(negedge clk);
    reset = 1;

    // Reset mid-count
    load = 1; d = 8'h37; cyc(); chk("load_37", int'(q), 8'h37);
    idle(); en = 1; cyc(); chk("count_38", int'(q), 8'h38);
    #2 reset = 0; model_reset();
    #1;
    chk("async_q", int'(q), 0);
    chk("async_tick", int'(tick), 0);
    chk("async_done", int'(done), 0);
    @(negedge clk); reset = 1;
    idle(); syn_clr = 1; lo = 8'h10; hi = 8'h14; cyc(); chk("clr_lo", int'(q), 8'h10);

    // Wrap up
    idle(); en = 1; up = 1; mode = 2'b00; step = 2;
    cyc(); chk("wrap1", int'(q), 8'h12);
    cyc(); chk("wrap2", int'(q), 8'h14); chk("wrap2_tick", int'(tick), 0);
    cyc(); chk("wrap3", int'(q), 8'h10); chk("wrap3_tick", int'(tick), 1);
    cyc(); chk("wrap4", int'(q), 8'h12);

    // Saturate down
    idle(); lo = 8'h05; hi = 8'h20; load = 1; d = 8'h0A; cyc();
    idle(); en = 1; up = 0; mode = 2'b01; step = 3;
    cyc(); chk("sat1", int'(q), 8'h07);
    cyc(); chk("sat2", int'(q), 8'h05); chk("sat2_tick", int'(tick), 1);
    cyc(); chk("sat3", int'(q), 8'h05); chk("sat3_tick", int'(tick), 1);
    chk("sat_min", int'(min_flag), 1);

    // One-shot up
    idle(); lo = 0; hi = 8'h0F; syn_clr = 1; cyc();
    idle(); en = 1; up = 1; mode = 2'b10; step = 5;
    cyc(); chk("os1", int'(q), 5);
    cyc(); chk("os2", int'(q), 8'h0A);
    cyc(); chk("os3", int'(q), 8'h0F); chk("os3_tick", int'(tick), 1);
    chk("os3_done", int'(done), 1);
    cyc(); chk("os_hold", int'(q), 8'h0F); chk("os_hold_tick", int'(tick), 0);
    mode = 2'b00; cyc(); chk("os_mode_done", int'(done), 1);
    idle(); load = 1; d = 8'h40; cyc();
    chk("os_load", int'(q), 8'h0F); chk("os_load_done", int'(done), 0);

    // Priority and config error
    idle(); lo = 8'h03; hi = 8'h50; d = 8'h20; syn_clr = 1; load = 1; en = 1;
    cyc(); chk("prio", int'(q), 8'h03);
    idle(); lo = 8'h30; hi = 8'h20; load = 1; d = 8'h25; en = 1;
    cyc(); chk("cfg_err", int'(cfg_err), 1); chk("cfg_hold", int'(q), 8'h03);
    idle(); syn_clr = 1; cyc(); chk("cfg_clr", int'(q), 8'h30);

    // step==0 and out-of-range start
    idle(); lo = 0; hi = 8'hFF; en = 1; step = 0;
    cyc(); chk("step0", int'(q), 8'h30); chk("step0_tick", int'(tick), 0);
    idle(); #2 reset = 0; model_reset(); @(negedge clk); reset = 1;
    lo = 8'h08; hi = 8'h40; en = 1; up = 0; step = 1;
    cyc(); chk("oor_down", int'(q), 8'h40); chk("oor_tick", int'(tick), 0);

    // lo == hi: every count is a boundary event
    idle(); lo = 8'h22; hi = 8'h22; syn_clr = 1; cyc();
    idle(); en = 1; up = 1; mode = 2'b00; step = 7;
    cyc(); chk("eq_q", int'(q), 8'h22); chk("eq_tick", int'(tick), 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) begin
        lo = N'($urandom_range(0, 200));
        hi = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 255))
                                         : N'(int'(lo) + $urandom_range(0, 55));
      end
      syn_clr = ($urandom_range(0, 31) == 0);
      load    = ($urandom_range(0, 15) == 0);
      en      = ($urandom_range(0, 3) != 0);
      if (i % 25 == 0) up = 1'($urandom_range(0, 1));
      if (i % 60 == 0) mode = 2'($urandom_range(0, 3));
      step    = ($urandom_range(0, 7) == 0) ? '0 : S'($urandom_range(1, 15));
      d       = N'($urandom_range(0, 255));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
